// File: rtl/instr_encoder.sv
// instr_encoder: scatters decoded fields plus a sign-extended immediate into
// 32-bit LOAD / STORE / COND_BRANCH encodings and tags every emitted word
// with an auto-incrementing instruction-memory word address.
// Optional build macro: IMM_RANGE_CHK_EN drops bundles whose immediate does
// not fit in the 12-bit field and flags err_range. Without it the immediate
// is truncated and err_range is tied low.
module instr_encoder #(
   parameter int INSTR_WIDTH  = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 10,
   parameter int ITYPE_OFFSET = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_class,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   input  logic [2:0]             in_funct3,
   input  logic [DATA_WIDTH-1:0]  in_imm,
   input  logic                   base_load,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0]  out_addr,
   output logic                   err_class,
   output logic                   err_range,
   input  logic                   clr_err
);

   localparam logic [1:0] CLASS_LOAD   = 2'd0;
   localparam logic [1:0] CLASS_STORE  = 2'd1;
   localparam logic [1:0] CLASS_BRANCH = 2'd2;
   localparam logic [1:0] CLASS_RSVD   = 2'd3;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic                   out_valid_reg, out_valid_next;
   logic [INSTR_WIDTH-1:0] out_instr_reg, out_instr_next;
   logic [ADDR_WIDTH-1:0]  out_addr_reg,  out_addr_next;
   logic [ADDR_WIDTH-1:0]  next_addr_reg, next_addr_next;
   logic                   err_class_reg, err_class_next;

   logic                   accept;
   logic                   is_rsvd;
   logic                   range_ok;
   logic                   emit;
   logic [11:0]            imm;
   logic [INSTR_WIDTH-1:0] enc;
   logic [ADDR_WIDTH-1:0]  word_addr;

   assign in_ready  = !out_valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign is_rsvd   = (in_class == CLASS_RSVD);
   assign emit      = accept && !is_rsvd && range_ok;
   assign imm       = in_imm[11:0];
   // base_load coincident with an accept redirects that very word
   assign word_addr = base_load ? base_addr : next_addr_reg;

   assign out_valid = out_valid_reg;
   assign out_instr = out_instr_reg;
   assign out_addr  = out_addr_reg;
   assign err_class = err_class_reg;

`ifdef IMM_RANGE_CHK_EN
   // Immediate fits when every bit from ITYPE_OFFSET-1 upward matches the
   // field's sign bit.
   logic [DATA_WIDTH-ITYPE_OFFSET:0] sign_match;
   logic                             err_range_reg, err_range_next;

   for (genvar gi = 0; gi <= DATA_WIDTH - ITYPE_OFFSET; gi++) begin : g_sign
      assign sign_match[gi] = (in_imm[ITYPE_OFFSET-1+gi] == in_imm[ITYPE_OFFSET-1]);
   end
   assign range_ok  = &sign_match;
   assign err_range = err_range_reg;

   // Sticky range error: a new violation wins over a clear in the same cycle
   always_comb begin
      err_range_next = err_range_reg;
      if (clr_err)
         err_range_next = 1'b0;
      if (accept && !is_rsvd && !range_ok)
         err_range_next = 1'b1;
   end

   // Range error register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_range_reg <= 1'b0;
      else
         err_range_reg <= err_range_next;
   end
`else
   // Upper immediate bits are intentionally discarded in this build
   logic unused_imm_upper;
   assign unused_imm_upper = ^in_imm[DATA_WIDTH-1:ITYPE_OFFSET];
   assign range_ok  = 1'b1;
   assign err_range = 1'b0;
`endif

   // Scatter the immediate and register fields into the class's encoding
   always_comb begin
      enc = '0;
      case (in_class)
         CLASS_LOAD:   enc = {imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
         CLASS_STORE:  enc = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], OP_STORE};
         CLASS_BRANCH: enc = {imm[11], imm[9:4], in_rs2, in_rs1, in_funct3,
                              imm[3:0], imm[10], OP_BRANCH};
         default:      enc = '0;
      endcase
   end

   // Output stage, address counter and sticky class error next-state
   always_comb begin
      out_valid_next = out_valid_reg;
      out_instr_next = out_instr_reg;
      out_addr_next  = out_addr_reg;
      next_addr_next = next_addr_reg;
      err_class_next = err_class_reg;

      if (emit) begin
         out_valid_next = 1'b1;
         out_instr_next = enc;
         out_addr_next  = word_addr;
         next_addr_next = word_addr + 1'b1;
      end else begin
         // held word consumed; a dropped/reserved bundle never re-arms valid
         if (out_ready)
            out_valid_next = 1'b0;
         if (base_load)
            next_addr_next = base_addr;
      end

      if (clr_err)
         err_class_next = 1'b0;
      if (accept && is_rsvd)
         err_class_next = 1'b1;
   end

   // State registers; reset discards any held word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_instr_reg <= '0;
         out_addr_reg  <= '0;
         next_addr_reg <= '0;
         err_class_reg <= 1'b0;
      end else begin
         out_valid_reg <= out_valid_next;
         out_instr_reg <= out_instr_next;
         out_addr_reg  <= out_addr_next;
         next_addr_reg <= next_addr_next;
         err_class_reg <= err_class_next;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: hand-computed encodings, handshake,
// address counter, base_load, wrap, reserved class and sticky errors.
`timescale 1ns/1ps
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_class;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [63:0] in_imm;
   logic        base_load;
   logic [9:0]  base_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;
   logic        err_class;
   logic        err_range;
   logic        clr_err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_imm(in_imm), .base_load(base_load),
      .base_addr(base_addr), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .err_class(err_class),
      .err_range(err_range), .clr_err(clr_err)
   );

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
      in_valid  = 1'b1;
      in_class  = c;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_imm    = imm;
   endtask

   task automatic do_reset();
      in_valid = 0; in_class = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0;
      in_imm = 0; base_load = 0; base_addr = 0; out_ready = 1; clr_err = 0;
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", out_instr); end
      vectors++; if (out_addr !== 10'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", out_addr); end
      vectors++; if ({err_class, err_range} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b exp 00", {err_class, err_range}); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_load();
      do_reset();
      drive(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8);
      step();
      in_valid = 0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL load_valid got %b exp 1", out_valid); end
      vectors++; if (out_instr !== 32'hFF813283) begin miscompares++; $display("FAIL load_instr got %h exp ff813283", out_instr); end
      vectors++; if (out_addr !== 10'h000) begin miscompares++; $display("FAIL load_addr got %h exp 000", out_addr); end
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_drain got %b exp 0", out_valid); end
      $display("load: instr=%h addr=%h", 32'hFF813283, 10'h0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(2'd1, 5'd0, 5'd1, 5'd4, 3'd3, 64'h24);
      step();
      drive(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'h410);
      vectors++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0240B223, 10'h000}) begin
         miscompares++; $display("FAIL b2b_store got v=%b %h @%h exp v=1 0240b223 @000", out_valid, out_instr, out_addr); end
      step();
      in_valid = 0;
      vectors++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h022080E3, 10'h001}) begin
         miscompares++; $display("FAIL b2b_branch got v=%b %h @%h exp v=1 022080e3 @001", out_valid, out_instr, out_addr); end
      step();
      $display("back_to_back: store @0, branch @1");
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 0;
      drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1);
      step();
      drive(2'd1, 5'd0, 5'd3, 5'd5, 3'd2, 64'h7FF);
      for (int i = 0; i < 3; i++) begin
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
         step();
         vectors++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h00100083, 10'h000}) begin
            miscompares++; $display("FAIL bp_hold[%0d] got v=%b %h @%h exp v=1 00100083 @000", i, out_valid, out_instr, out_addr); end
      end
      out_ready = 1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_ret got %b exp 1", in_ready); end
      step();
      in_valid = 0;
      vectors++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h7E51AFA3, 10'h001}) begin
         miscompares++; $display("FAIL bp_second got v=%b %h @%h exp v=1 7e51afa3 @001", out_valid, out_instr, out_addr); end
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b exp 0", out_valid); end
      $display("backpressure: held 3 cycles, words @0,@1 in order");
   endtask

   task automatic test_base_wrap();
      do_reset();
      base_load = 1; base_addr = 10'h3FF;
      drive(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8);
      step();
      base_load = 0;
      drive(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'h410);
      vectors++; if (out_addr !== 10'h3FF) begin miscompares++; $display("FAIL base_addr got %h exp 3ff", out_addr); end
      step();
      in_valid = 0;
      vectors++; if ({out_instr, out_addr} !== {32'h022080E3, 10'h000}) begin
         miscompares++; $display("FAIL wrap_addr got %h @%h exp 022080e3 @000", out_instr, out_addr); end
      step();
      // base_load alone redirects the following word
      base_load = 1; base_addr = 10'h100;
      step();
      base_load = 0;
      drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1);
      step();
      in_valid = 0;
      vectors++; if ({out_valid, out_addr} !== {1'b1, 10'h100}) begin
         miscompares++; $display("FAIL base_alone got v=%b @%h exp v=1 @100", out_valid, out_addr); end
      step();
      $display("base_wrap: @3ff, @000, base_load alone @100");
   endtask

   task automatic test_reserved();
      do_reset();
      drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1);
      step();
      in_valid = 0;
      step();
      drive(2'd3, 5'd7, 5'd7, 5'd7, 3'd7, 64'h5);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rsvd_ready got %b exp 1", in_ready); end
      step();
      in_valid = 0;
      vectors++; if ({out_valid, err_class} !== 2'b01) begin
         miscompares++; $display("FAIL rsvd_accept got v=%b err=%b exp v=0 err=1", out_valid, err_class); end
      drive(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8);
      step();
      in_valid = 0;
      vectors++; if ({out_valid, out_addr} !== {1'b1, 10'h001}) begin
         miscompares++; $display("FAIL rsvd_next_addr got v=%b @%h exp v=1 @001", out_valid, out_addr); end
      step();
      // set wins over clear in the same cycle
      drive(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0);
      clr_err = 1;
      step();
      in_valid = 0;
      vectors++; if (err_class !== 1'b1) begin miscompares++; $display("FAIL rsvd_set_wins got %b exp 1", err_class); end
      step();
      clr_err = 0;
      vectors++; if (err_class !== 1'b0) begin miscompares++; $display("FAIL rsvd_clear got %b exp 0", err_class); end
      $display("reserved: accepted, not emitted, err_class set then cleared");
   endtask

   task automatic test_range();
      do_reset();
      drive(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'h800);
      step();
      in_valid = 0;
`ifdef IMM_RANGE_CHK_EN
      vectors++; if ({out_valid, err_range} !== 2'b01) begin
         miscompares++; $display("FAIL range_drop got v=%b err=%b exp v=0 err=1", out_valid, err_range); end
      drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1);
      step();
      in_valid = 0;
      vectors++; if ({out_valid, out_addr} !== {1'b1, 10'h000}) begin
         miscompares++; $display("FAIL range_no_inc got v=%b @%h exp v=1 @000", out_valid, out_addr); end
      clr_err = 1;
      step();
      clr_err = 0;
      vectors++; if (err_range !== 1'b0) begin miscompares++; $display("FAIL range_clear got %b exp 0", err_range); end
`else
      vectors++; if ({out_valid, out_instr[31:20], err_range} !== {1'b1, 12'h800, 1'b0}) begin
         miscompares++; $display("FAIL range_trunc got v=%b imm=%h err=%b exp v=1 imm=800 err=0", out_valid, out_instr[31:20], err_range); end
      step();
`endif
      $display("range: imm=800 checked");
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 0;
      drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1);
      step();
      in_valid = 0;
      reset = 1;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid got %b exp 0", out_valid); end
      step();
      reset = 0;
      out_ready = 1;
      vectors++; if (out_addr !== 10'h0) begin miscompares++; $display("FAIL reset_mid_addr got %h exp 0", out_addr); end
      $display("reset_mid: held word discarded");
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_backpressure();
      test_base_wrap();
      test_reserved();
      test_range();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
